jpeg_block_sequencer: RTL and testbench

Control FSM for the 8x8 JPEG encode datapath. It accepts one 64-pixel block from upstream and pulses the capture enable of the 64x8 input buffer. It then issues the row pass and the column pass through the shared 1-D DCT unit, with write-back timing matched to the DCT pipeline. Finally it streams the 64 zigzag-ordered coefficients to downstream under a valid/ready handshake.

---
 rtl/jpeg_block_sequencer.sv | 119 +++++++++++
 tb/tb_jpeg_block_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/jpeg_block_sequencer.sv
// Control FSM for the 8x8 JPEG encode datapath: block capture, row and
// column DCT passes with matched write-back timing, zigzag coefficient output.
module jpeg_block_sequencer #(
    parameter int DCT_LATENCY = 3,
    parameter int N           = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       blk_valid,
    output logic       blk_ready,
    output logic       input_enable,
    output logic       dct_start,
    output logic       dct_pass,
    output logic [2:0] dct_idx,
    output logic       dct_wr,
    output logic [2:0] dct_wr_idx,
    output logic       output_enable,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [5:0] coef_idx,
    output logic       busy,
    output logic       blk_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_OUT
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [5:0]             r_coef;
    logic                   r_done;
    logic [DCT_LATENCY-1:0] r_pv;
    logic [2:0]             r_pidx [DCT_LATENCY];

    logic w_pass_act;
    logic w_start;
    logic w_wr;
    logic w_pass_end;
    logic w_hs;

    assign w_pass_act = (r_state == S_ROW) || (r_state == S_COL);
    assign w_start    = w_pass_act && (r_cnt < 4'(N));
    assign w_wr       = r_pv[DCT_LATENCY-1];
    // A pass ends only once its final result has been written back.
    assign w_pass_end = w_pass_act && !w_start && w_wr
                        && (r_pidx[DCT_LATENCY-1] == 3'(N-1));
    assign w_hs       = (r_state == S_OUT) && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_coef  <= '0;
            r_done  <= 1'b0;
            r_pv    <= '0;
            for (int i = 0; i < DCT_LATENCY; i++) begin
                r_pidx[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            for (int i = DCT_LATENCY-1; i > 0; i--) begin
                r_pv[i]   <= r_pv[i-1];
                r_pidx[i] <= r_pidx[i-1];
            end
            r_pv[0]   <= w_start;
            r_pidx[0] <= r_cnt[2:0];

            unique case (r_state)
                S_IDLE: begin
                    if (blk_valid) begin
                        r_state <= S_ROW;
                        r_cnt   <= '0;
                    end
                end
                S_ROW, S_COL: begin
                    if (w_start) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                    if (w_pass_end) begin
                        r_cnt   <= '0;
                        r_state <= (r_state == S_ROW) ? S_COL : S_OUT;
                    end
                end
                S_OUT: begin
                    if (w_hs) begin
                        if (r_coef == 6'd63) begin
                            r_coef  <= '0;
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_coef <= r_coef + 6'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign blk_ready     = (r_state == S_IDLE);
    assign input_enable  = blk_valid && blk_ready;
    assign dct_start     = w_start;
    assign dct_pass      = (r_state == S_COL);
    assign dct_idx       = w_start ? r_cnt[2:0] : 3'd0;
    assign dct_wr        = w_wr;
    assign dct_wr_idx    = w_wr ? r_pidx[DCT_LATENCY-1] : 3'd0;
    assign out_valid     = (r_state == S_OUT);
    assign output_enable = w_hs;
    assign out_last      = out_valid && (r_coef == 6'd63);
    assign coef_idx      = r_coef;
    assign busy          = (r_state != S_IDLE);
    assign blk_done      = r_done;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Scoreboard bench: two sequencers (latency 3 and 1) share stimulus and are
// checked cycle by cycle against a timeline model derived from accept time.
module tb_jpeg_block_sequencer;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic blk_valid = 1'b0;
    logic out_ready = 1'b0;

    always #5 clock = ~clock;

    localparam int LAT [2] = '{3, 1};

    logic [1:0] br, ie, st, ps, wr, oe, ov, ol, bs, bd;
    logic [2:0] ix [2];
    logic [2:0] wx [2];
    logic [5:0] ci [2];
    logic [21:0] act [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        jpeg_block_sequencer #(
            .DCT_LATENCY((g == 0) ? 3 : 1),
            .N(8)
        ) u_dut (
            .clock(clock),
            .reset_n(reset_n),
            .blk_valid(blk_valid),
            .blk_ready(br[g]),
            .input_enable(ie[g]),
            .dct_start(st[g]),
            .dct_pass(ps[g]),
            .dct_idx(ix[g]),
            .dct_wr(wr[g]),
            .dct_wr_idx(wx[g]),
            .output_enable(oe[g]),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_last(ol[g]),
            .coef_idx(ci[g]),
            .busy(bs[g]),
            .blk_done(bd[g])
        );
        assign act[g] = {br[g], ie[g], st[g], ps[g], ix[g], wr[g],
                         wx[g], oe[g], ov[g], ol[g], ci[g], bs[g], bd[g]};
    end

    logic [21:0] sbq0 [$];
    logic [21:0] sbq1 [$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bit m_idle [2] = '{1'b1, 1'b1};
    bit m_done [2] = '{1'b0, 1'b0};
    int m_t0 [2];
    int m_hs [2];

    // Expected outputs from the block timeline: rel = cycles since accept.
    task automatic model(input int k, input bit bv, input bit ordy,
                         input bit rst, output logic [21:0] e);
        bit xbr = 0, xie = 0, xst = 0, xps = 0, xwr = 0;
        bit xoe = 0, xov = 0, xol = 0, xbs = 0, xbd = 0;
        logic [2:0] xix = 0, xwx = 0;
        logic [5:0] xci = 0;
        int L = LAT[k];
        int rel;
        if (!rst) begin
            m_idle[k] = 1;
            m_done[k] = 0;
        end
        if (m_idle[k]) begin
            xbr = 1;
            xie = bv;
            xbd = m_done[k];
            m_done[k] = 0;
            if (rst && bv) begin
                m_idle[k] = 0;
                m_t0[k] = cyc;
                m_hs[k] = 0;
            end
        end else begin
            rel = cyc - m_t0[k];
            xbs = 1;
            if (rel >= 1 && rel <= 8) begin
                xst = 1;
                xix = 3'(rel - 1);
            end
            if (rel >= 9 + L && rel <= 16 + L) begin
                xst = 1;
                xix = 3'(rel - 9 - L);
            end
            if (rel >= 1 + L && rel <= 8 + L) begin
                xwr = 1;
                xwx = 3'(rel - 1 - L);
            end
            if (rel >= 9 + 2*L && rel <= 16 + 2*L) begin
                xwr = 1;
                xwx = 3'(rel - 9 - 2*L);
            end
            xps = (rel >= 9 + L) && (rel < 17 + 2*L);
            if (rel >= 17 + 2*L) begin
                xov = 1;
                xci = 6'(m_hs[k]);
                xol = (m_hs[k] == 63);
                xoe = ordy;
                if (ordy) begin
                    if (m_hs[k] == 63) begin
                        m_idle[k] = 1;
                        m_done[k] = 1;
                    end
                    m_hs[k]++;
                end
            end
        end
        e = {xbr, xie, xst, xps, xix, xwr, xwx, xoe, xov, xol, xci, xbs, xbd};
    endtask

    task automatic cycle(input bit bv, input bit ordy, input bit rst);
        logic [21:0] e0, e1;
        @(posedge clock);
        #1;
        blk_valid = bv;
        out_ready = ordy;
        reset_n = rst;
        model(0, bv, ordy, rst, e0);
        model(1, bv, ordy, rst, e1);
        sbq0.push_back(e0);
        sbq1.push_back(e1);
        cyc++;
    endtask

    task automatic chk(input int k, input logic [21:0] exp_v);
        vectors++;
        if (act[k] !== exp_v) begin
            miscompares++;
            $display("FAIL outputs L=%0d t=%0t got=%h exp=%h",
                     LAT[k], $time, act[k], exp_v);
        end
    endtask

    always @(negedge clock) begin
        if (sbq0.size() > 0) chk(0, sbq0.pop_front());
        if (sbq1.size() > 0) chk(1, sbq1.pop_front());
    end

    initial begin
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1);
        // single block, out_ready held high
        cycle(1, 1, 1);
        for (int i = 0; i < 100; i++) cycle(0, 1, 1);
        // alternating backpressure
        cycle(1, 1, 1);
        for (int i = 0; i < 180; i++) cycle(0, cyc[0], 1);
        // back-to-back with blk_valid held high
        for (int i = 0; i < 200; i++) cycle(1, 1, 1);
        for (int i = 0; i < 110; i++) cycle(0, 1, 1);
        // reset during the column pass
        cycle(1, 1, 1);
        for (int i = 0; i < 13; i++) cycle(0, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        for (int i = 0; i < 40; i++) cycle(0, 1, 1);
        // random traffic with rare resets
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 499) != 0);
        end
        @(negedge clock);
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
